// File: rtl/hmc_host_link_seq_if.sv
// HMC host sideband pins: device reset, boot-clock select and power-state handshake.
// The host drives P_RST_N, REFCLK_BOOT and RXPS; the device drives TXPS and FERR_N.
interface hmc_host_link_seq_if;
    logic       P_RST_N;
    logic [1:0] REFCLK_BOOT;
    logic       RXPS;
    logic       TXPS;
    logic       FERR_N;

    modport master (
        output P_RST_N,
        output REFCLK_BOOT,
        output RXPS,
        input  TXPS,
        input  FERR_N
    );

    modport slave (
        input  P_RST_N,
        input  REFCLK_BOOT,
        input  RXPS,
        output TXPS,
        output FERR_N
    );
endinterface

// File: rtl/hmc_host_link_seq.sv
// Host-side HMC link bring-up and power-state sequencer.
// Holds the device in reset, releases it, waits for the TXPS handshake,
// manages sleep/wake through RXPS/TXPS, and traps timeouts and FERR_N faults.
module hmc_host_link_seq #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int PS_TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic [1:0]                 cfg_refclk_boot,
    input  logic                       start,
    input  logic                       sleep_req,
    input  logic                       wake_req,
    input  logic                       err_clr,
    hmc_host_link_seq_if.master        dev_if,
    output logic                       link_up,
    output logic                       sleeping,
    output logic                       fatal_err,
    output logic                       timeout_err,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RST_HOLD    = 3'd1,
        ST_WAIT_TXPS   = 3'd2,
        ST_ACTIVE      = 3'd3,
        ST_SLEEP_ENTRY = 3'd4,
        ST_SLEEP       = 3'd5,
        ST_WAKE        = 3'd6,
        ST_ERROR       = 3'd7
    } state_e;

    // Last counter value of each timed state; the state lasts (value + 1) cycles.
    localparam logic [7:0] LP_HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);
    localparam logic [7:0] LP_PS_LAST   = 8'(PS_TIMEOUT - 1);

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic        r_txps_meta;
    logic        r_txps_sync;
    logic        r_ferr_n_meta;
    logic        r_ferr_n_sync;
    logic        r_p_rst_n;
    logic [1:0]  r_refclk_boot;
    logic        r_rxps;
    logic        r_link_up;
    logic        r_sleeping;
    logic        r_fatal_err;
    logic        r_timeout_err;

    state_e      w_state_nxt;
    logic        w_set_fatal;
    logic        w_set_timeout;
    logic        w_clr_err;
    logic        w_latch_boot;
    logic        w_link_phase;
    logic        w_hold_done;
    logic        w_ps_expired;

    // Two-flop synchronizers for the device's asynchronous status pins.
    // FERR_N idles high so a reset never looks like a device fault.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_txps_meta   <= 1'b0;
            r_txps_sync   <= 1'b0;
            r_ferr_n_meta <= 1'b1;
            r_ferr_n_sync <= 1'b1;
        end else begin
            r_txps_meta   <= dev_if.TXPS;
            r_txps_sync   <= r_txps_meta;
            r_ferr_n_meta <= dev_if.FERR_N;
            r_ferr_n_sync <= r_ferr_n_meta;
        end
    end

    assign w_link_phase = (r_state inside {ST_WAIT_TXPS, ST_ACTIVE, ST_SLEEP_ENTRY,
                                           ST_SLEEP, ST_WAKE});
    assign w_hold_done  = (r_cnt >= LP_HOLD_LAST);
    assign w_ps_expired = (r_cnt >= LP_PS_LAST);

    // Next-state decision; a device fault during the link phases overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_state_nxt   = r_state;
        w_set_fatal   = 1'b0;
        w_set_timeout = 1'b0;
        w_clr_err     = 1'b0;
        w_latch_boot  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_RST_HOLD;
                    w_latch_boot = 1'b1;
                end
            end
            ST_RST_HOLD: begin
                if (w_hold_done) w_state_nxt = ST_WAIT_TXPS;
            end
            ST_WAIT_TXPS: begin
                if (r_txps_sync) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_ps_expired) begin
                    w_state_nxt   = ST_ERROR;
                    w_set_timeout = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (sleep_req) w_state_nxt = ST_SLEEP_ENTRY;
            end
            ST_SLEEP_ENTRY: begin
                if (!r_txps_sync) begin
                    w_state_nxt = ST_SLEEP;
                end else if (w_ps_expired) begin
                    w_state_nxt   = ST_ERROR;
                    w_set_timeout = 1'b1;
                end
            end
            ST_SLEEP: begin
                // wake_req wins over a concurrent sleep_req; sleep_req has no effect here.
                if (wake_req) w_state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (r_txps_sync) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_ps_expired) begin
                    w_state_nxt   = ST_ERROR;
                    w_set_timeout = 1'b1;
                end
            end
            ST_ERROR: begin
                // A still-active fault beats the clear request.
                if (!r_ferr_n_sync) begin
                    w_set_fatal = 1'b1;
                end else if (err_clr) begin
                    w_clr_err   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_link_phase && !r_ferr_n_sync) begin
            w_state_nxt   = ST_ERROR;
            w_set_fatal   = 1'b1;
            w_set_timeout = 1'b0;
        end
    end

    // FSM state, saturating per-state counter, sticky errors and pin outputs.
    // Outputs decode the next state so pins change on the same edge as the state.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_p_rst_n     <= 1'b0;
            r_refclk_boot <= 2'b00;
            r_rxps        <= 1'b1;
            r_link_up     <= 1'b0;
            r_sleeping    <= 1'b0;
            r_fatal_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_latch_boot) r_refclk_boot <= cfg_refclk_boot;

            if (w_clr_err) begin
                r_fatal_err   <= 1'b0;
                r_timeout_err <= 1'b0;
            end else begin
                if (w_set_fatal)   r_fatal_err   <= 1'b1;
                if (w_set_timeout) r_timeout_err <= 1'b1;
            end

            r_p_rst_n  <= (w_state_nxt inside {ST_WAIT_TXPS, ST_ACTIVE, ST_SLEEP_ENTRY,
                                               ST_SLEEP, ST_WAKE});
            r_rxps     <= !(w_state_nxt inside {ST_SLEEP_ENTRY, ST_SLEEP});
            r_link_up  <= (w_state_nxt == ST_ACTIVE);
            r_sleeping <= (w_state_nxt == ST_SLEEP);
        end
    end

    assign dev_if.P_RST_N     = r_p_rst_n;
    assign dev_if.REFCLK_BOOT = r_refclk_boot;
    assign dev_if.RXPS        = r_rxps;
    assign link_up            = r_link_up;
    assign sleeping           = r_sleeping;
    assign fatal_err          = r_fatal_err;
    assign timeout_err        = r_timeout_err;
    assign state              = r_state;

endmodule

// File: doc/hmc_host_link_seq.md
HMC_HOST_LINK_SEQ -- requirements
Module: hmc_host_link_seq

Interface
REQ-001 The block SHALL take parameter RST_HOLD_CYCLES, default 16: number of clk cycles P_RST_N is held low during bring-up.
REQ-002 The block SHALL take parameter PS_TIMEOUT, default 255: maximum clk cycles to wait for the TXPS response, range 1..255.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port res_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port cfg_refclk_boot, input, 2: requested REFCLK_BOOT code (00=125 MHz, 01=156.25 MHz, 10=166.67 MHz).
REQ-006 The block SHALL have port start, input, 1: one-cycle request to begin link bring-up.
REQ-007 The block SHALL have port sleep_req, input, 1: request power reduction.
REQ-008 The block SHALL have port wake_req, input, 1: request wake from power reduction.
REQ-009 The block SHALL have port err_clr, input, 1: clear sticky errors and leave ERROR.
REQ-010 The block SHALL have port TXPS, input, 1: device power-state output, asynchronous to clk.
REQ-011 The block SHALL have port FERR_N, input, 1: device fatal-error output, active-low, asynchronous to clk.
REQ-012 The block SHALL have port P_RST_N, output, 1: device reset, active-low.
REQ-013 The block SHALL have port REFCLK_BOOT, output, 2: latched boot-frequency code driven to the device.
REQ-014 The block SHALL have port RXPS, output, 1: device power-reduction input; 1 = active, 0 = sleep.
REQ-015 The block SHALL have ports link_up, sleeping, fatal_err, timeout_err (output, 1 each) and state (output, 3).

Function
REQ-016 TXPS and FERR_N SHALL each pass through a 2-flop synchronizer, so the FSM sees an input change 2 cycles later; the synchronizer flops SHALL reset to 0 and 1 respectively.
REQ-017 FSM state encodings: IDLE=0, RST_HOLD=1, WAIT_TXPS=2, ACTIVE=3, SLEEP_ENTRY=4, SLEEP=5, WAKE=6, ERROR=7; the state output SHALL equal the current encoding.
REQ-018 IDLE: P_RST_N=0, RXPS=1; on start, the block SHALL latch cfg_refclk_boot into REFCLK_BOOT, clear the counter and go to RST_HOLD.
REQ-019 RST_HOLD: P_RST_N=0; the state SHALL last exactly RST_HOLD_CYCLES cycles, then go to WAIT_TXPS.
REQ-020 WAIT_TXPS: P_RST_N=1, RXPS=1; on synced TXPS=1 the FSM SHALL go to ACTIVE; otherwise, after PS_TIMEOUT cycles it SHALL set timeout_err and go to ERROR.
REQ-021 ACTIVE: link_up=1; on sleep_req the FSM SHALL go to SLEEP_ENTRY; wake_req SHALL be ignored.
REQ-022 SLEEP_ENTRY: RXPS=0; on synced TXPS=0 the FSM SHALL go to SLEEP; on timeout it SHALL set timeout_err and go to ERROR.
REQ-023 SLEEP: RXPS=0, sleeping=1; on wake_req the FSM SHALL go to WAKE, with wake_req taking priority if sleep_req is also high.
REQ-024 WAKE: RXPS=1; on synced TXPS=1 the FSM SHALL go to ACTIVE; on timeout it SHALL set timeout_err and go to ERROR.
REQ-025 In the states WAIT_TXPS through WAKE, synced FERR_N=0 SHALL set fatal_err and force ERROR next cycle, with priority over every other transition.
REQ-026 ERROR: P_RST_N=0, RXPS=1, link_up=0; on err_clr with synced FERR_N=1 the block SHALL clear both sticky errors and go to IDLE; if FERR_N=0 in the same cycle, the fault SHALL win.
REQ-027 The timeout counter SHALL be 8-bit, SHALL clear on every state entry, and SHALL saturate rather than wrap.
REQ-028 start SHALL be ignored outside IDLE; REFCLK_BOOT SHALL change only on the latch in IDLE.
REQ-029 All outputs SHALL be registered, with one cycle of latency from FSM decision to pin.

Reset
REQ-030 While res_n=0, the block SHALL be in IDLE with P_RST_N=0, REFCLK_BOOT=00, RXPS=1, link_up=0, sleeping=0, fatal_err=0, timeout_err=0, state=0, and counter=0.
REQ-031 Assertion of res_n in any state, including mid-handshake, SHALL take effect immediately and asynchronously; deassertion SHALL resume from IDLE.

Verification
REQ-032 Scenario: start with cfg_refclk_boot=01 and TXPS=1 -> REFCLK_BOOT=01, P_RST_N low for 16 cycles, link_up=1 within 4 cycles of P_RST_N rising.
REQ-033 Scenario: in ACTIVE, sleep_req then TXPS falls -> RXPS=0, sleeping=1 at 3 cycles after the TXPS fall; then wake_req and TXPS rises -> ACTIVE again, link_up=1.
REQ-034 Scenario: TXPS held 0 after reset release -> timeout_err=1, state=7 after 255 cycles in WAIT_TXPS, P_RST_N=0.
REQ-035 Scenario: FERR_N pulled low in SLEEP -> fatal_err=1, state=7 within 3 cycles; err_clr while FERR_N=0 -> state stays 7.
REQ-036 Scenario: res_n asserted during SLEEP_ENTRY -> all outputs take their reset values immediately, without waiting for a clk edge.
REQ-037 Scenario: sleep_req and wake_req high simultaneously in SLEEP -> the FSM goes to WAKE.
